// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: state encoding and default frame width shared by the shift sequencer
package shift_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, DONE = 2'd3} state_t;
  localparam int WIDTH_DEF = 5;
endpackage

// File: rtl/shift_reg_pl.sv
// shift_reg_pl: parallel-load, zero-fill right-shift register; load wins over shift
module shift_reg_pl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    q <= rst ? '0 : load ? d : shift ? q >> 1 : q;
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: LSB-first serializer FSM with stall control; define PARITY_EN to append an even-parity bit
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] q;
  logic accept;
  assign accept = load_valid && load_ready;
  shift_reg_pl #(.WIDTH(WIDTH)) u_sreg (
    .clk  (clock),
    .rst  (Reset),
    .load (accept),
    .shift(state == SHIFT && shift_en),
    .d    (load_data),
    .q    (q)
  );
`ifdef PARITY_EN
  logic par;
  always_ff @(posedge clock)
    par <= Reset ? 1'b0 : accept ? ^load_data : par;
  assign sout       = state == SHIFT ? q[0] : state == PARITY ? par : 1'b0;
  assign sout_valid = shift_en && (state == SHIFT || state == PARITY);
`else
  assign sout       = state == SHIFT ? q[0] : 1'b0;
  assign sout_valid = shift_en && state == SHIFT;
`endif
  assign load_ready = state == IDLE;
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  always_ff @(posedge clock) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (load_valid) begin
          state <= SHIFT;
          cnt   <= '0;
        end
        SHIFT: if (shift_en) begin
          cnt <= cnt + 1'b1;
`ifdef PARITY_EN
          if (cnt == LAST) state <= PARITY;
`else
          if (cnt == LAST) state <= DONE;
`endif
        end
`ifdef PARITY_EN
        PARITY: if (shift_en) state <= DONE;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 5, number of data bits per frame (WIDTH >= 2).
REQ-002 Port: clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-004 Port: load_valid  input  1  requester offers a parallel word.
REQ-005 Port: load_data  input  WIDTH  parallel word; sampled only on acceptance.
REQ-006 Port: load_ready  output  1  controller can accept a word (IDLE only).
REQ-007 Port: shift_en  input  1  stall control; low freezes the frame in SHIFT/PARITY.
REQ-008 Port: sout  output  1  serial data bit, LSB first.
REQ-009 Port: sout_valid  output  1  sout carries a frame bit this cycle.
REQ-010 Port: busy  output  1  high in any state other than IDLE.
REQ-011 Port: done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-012 States SHALL be IDLE, SHIFT, PARITY, DONE; PARITY exists only with PARITY_EN.
REQ-013 Acceptance SHALL occur when load_valid && load_ready at a rising edge: load_data is loaded into the shift register, bit counter cleared, and the state goes to SHIFT.
REQ-014 load_ready SHALL be 1 exactly in IDLE; load_valid outside IDLE is ignored and has no side effect.
REQ-015 In SHIFT, sout SHALL equal shift register bit 0 and sout_valid SHALL be 1, so the first bit appears the cycle after acceptance (latency 1).
REQ-016 In SHIFT, at each edge with shift_en=1, the register SHALL shift right by one (zero fill) and the counter SHALL increment; with shift_en=0, register, counter and sout SHALL hold, and sout_valid SHALL be 0.
REQ-017 After WIDTH advancing SHIFT cycles, the next state SHALL be PARITY (PARITY_EN) or DONE.
REQ-018 PARITY SHALL drive sout = even-parity bit (XOR of the accepted word) with sout_valid=1, advance to DONE on shift_en=1, and hold on shift_en=0.
REQ-019 DONE SHALL last exactly one cycle with done=1, sout_valid=0 and load_ready=0, then return to IDLE.
REQ-020 Back-to-back frames: a word SHALL be accepted no earlier than the cycle after DONE (minimum gap of one IDLE cycle).
REQ-021 In IDLE and DONE, sout SHALL be 0.
REQ-022 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap within a frame.

Reset
REQ-023 Reset=1 at an edge SHALL force IDLE, clear the shift register, counter and parity, and drive sout=0, sout_valid=0, busy=0, done=0, load_ready=1 on the next cycle.
REQ-024 Reset SHALL override acceptance and shift_en; a frame in progress is aborted without a done pulse.

Configuration
REQ-025 Macro PARITY_EN SHALL gate the parity feature: when defined, each frame is WIDTH data bits plus one even-parity bit; when undefined, the PARITY state and parity logic are absent and the frame is WIDTH bits.

Structure
REQ-026 Shared package shift_seq_pkg SHALL hold the state encoding (IDLE=0, SHIFT=1, PARITY=2, DONE=3) and the default WIDTH constant.
REQ-027 The datapath SHALL be a sub-module shift_reg_pl (parallel-load, right-shift register with load/shift enables); shift_seq_ctrl holds the FSM, counter and parity.

Verification
REQ-028 Reset held for 2 cycles mid-frame -> all outputs 0, load_ready=1, no done pulse.
REQ-029 WIDTH=5, load 5'b10110, shift_en=1 -> sout 0,1,1,0,1 on cycles 1-5 after acceptance; done=1 on cycle 6 (no PARITY_EN) or parity bit 1 on cycle 6 and done on cycle 7 (PARITY_EN).
REQ-030 Load 5'b00111 with shift_en=0 on cycles 2-3 -> sout_valid=0 and sout held on those cycles; sequence 1,1,1,0,0 preserved; done delayed by 2 cycles.
REQ-031 load_valid held high continuously with alternating words 5'h15/5'h0A -> load_ready=0 while busy, each word accepted exactly once, one IDLE cycle between frames.
REQ-032 With PARITY_EN, load 5'b00000 -> parity bit 0; load 5'b11111 -> parity bit 1.
REQ-033 load_valid pulsed during SHIFT with 5'h1F -> ignored; the current frame's bits are unchanged.
